sram_fb_writer: RTL

- Write-side master for the external 256Kx16 framebuffer SRAM; complements the video scan-out reader in gensquares.
- Accepts pixel/word write requests on a valid/ready port and buffers them in an internal FIFO.
- Performs timed SRAM write cycles only while the video arbiter grants the bus.
- Drives active-high ram_* strobes in the same form as gensquares; the top level muxes the two masters onto sram_* pins.

---
 rtl/sram_fb_writer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/sram_fb_writer.sv
// sram_fb_writer: write-side master for the 256Kx16 framebuffer SRAM.
// Buffers write requests in a small FIFO and issues timed SRAM write cycles
// (SETUP, WRITE x WE_CYCLES, HOLD) only while the video arbiter grants the bus.
// Optional read-back verification is enabled by defining SRAM_WR_VERIFY_EN.
module sram_fb_writer #(
   parameter int FIFO_DEPTH = 8,
   parameter int WE_CYCLES  = 2,
   parameter int ADDR_W     = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [15:0]       wr_data,
   input  logic [1:0]        wr_be,
   output logic              bus_req,
   input  logic              bus_gnt,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [15:0]       ram_dout,
   output logic              ram_ce,
   output logic              ram_oe,
   output logic              ram_we,
   output logic              ram_lb,
   output logic              ram_hb,
   output logic              busy
`ifdef SRAM_WR_VERIFY_EN
   ,
   input  logic [15:0]       ram_din,
   output logic [7:0]        err_count
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_WRITE,
      S_HOLD
`ifdef SRAM_WR_VERIFY_EN
      , S_VERIFY_A,
      S_VERIFY_B
`endif
   } state_t;

   state_t state, next_state;

   logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
   logic [15:0]       data_mem [FIFO_DEPTH];
   logic [1:0]        be_mem   [FIFO_DEPTH];
   logic [PW:0]       wr_ptr, rd_ptr;
   logic              empty, full, push, pop, load, head_ok, can_start;
   logic [1:0]        head_be;
   logic [3:0]        we_cnt;

   // Full/empty come from the extra pointer bit, so wr_ready never sees a same-cycle pop.
   assign empty     = (wr_ptr == rd_ptr);
   assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign wr_ready  = !full;
   assign push      = wr_valid && !full;
   assign head_be   = be_mem[rd_ptr[PW-1:0]];
   assign head_ok   = !empty && (head_be != 2'b00);
   assign can_start = head_ok && bus_gnt;
   assign busy      = !empty || (state != S_IDLE);

   // FIFO storage writes.
   // NOTE: the storage arrays carry no reset; the pointers alone define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr[PW-1:0]] <= wr_addr;
         data_mem[wr_ptr[PW-1:0]] <= wr_data;
         be_mem[wr_ptr[PW-1:0]]   <= wr_be;
      end
   end

   // FIFO pointers; reset flushes any queued requests.
   // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= next_state;
   end

   // Next-state decode, FIFO pop and output-register load strobe.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      next_state = state;
      pop        = 1'b0;
      load       = 1'b0;
      case (state)
         S_IDLE: begin
            if (!empty && head_be == 2'b00) begin
               pop = 1'b1;              // empty byte mask: drop it, no bus cycle
            end else if (can_start) begin
               pop        = 1'b1;
               load       = 1'b1;
               next_state = S_SETUP;
            end
         end
         S_SETUP: next_state = S_WRITE;
         S_WRITE: if (we_cnt == 4'd0) next_state = S_HOLD;
`ifdef SRAM_WR_VERIFY_EN
         S_HOLD:     next_state = S_VERIFY_A;
         S_VERIFY_A: next_state = S_VERIFY_B;
         S_VERIFY_B: begin
`else
         S_HOLD: begin
`endif
            if (can_start) begin
               pop        = 1'b1;
               load       = 1'b1;
               next_state = S_SETUP;
            end else begin
               next_state = S_IDLE;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   // WE pulse length down-counter, loaded during SETUP.
   always_ff @(posedge clk) begin
      if (reset)                               we_cnt <= 4'd0;
      else if (state == S_SETUP)               we_cnt <= 4'(WE_CYCLES - 1);
      else if (state == S_WRITE && we_cnt != 0) we_cnt <= we_cnt - 4'd1;
   end

   // Registered SRAM address/data/strobes so the pins are glitch-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_addr <= '0;
         ram_dout <= '0;
         ram_ce   <= 1'b0;
         ram_we   <= 1'b0;
         ram_lb   <= 1'b0;
         ram_hb   <= 1'b0;
         bus_req  <= 1'b0;
      end else begin
         ram_ce  <= (next_state != S_IDLE);
         ram_we  <= (next_state == S_WRITE);
         bus_req <= head_ok || (state == S_SETUP) || (state == S_WRITE);
         if (load) begin
            ram_addr <= addr_mem[rd_ptr[PW-1:0]];
            ram_dout <= data_mem[rd_ptr[PW-1:0]];
            ram_lb   <= head_be[0];
            ram_hb   <= head_be[1];
         end else if (next_state == S_IDLE) begin
            ram_lb   <= 1'b0;           // strobes low in IDLE so the reader owns the bus
            ram_hb   <= 1'b0;
         end
      end
   end

`ifdef SRAM_WR_VERIFY_EN
   logic mismatch;
   assign mismatch = (ram_lb && ram_din[7:0]  != ram_dout[7:0]) ||
                     (ram_hb && ram_din[15:8] != ram_dout[15:8]);

   // Read-back output enable and saturating error counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         ram_oe    <= 1'b0;
         err_count <= 8'd0;
      end else begin
         ram_oe <= (next_state == S_VERIFY_A) || (next_state == S_VERIFY_B);
         if (state == S_VERIFY_B && mismatch && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
      end
   end
`else
   assign ram_oe = 1'b0;
`endif

endmodule
